p405s_dvc_event_ctl: RTL and testbench
======================================

# p405s_dvc_event_ctl

Debug data-value-compare (DVC) event controller. It consumes the per-byte DVC compare vectors produced in EXE, qualifies them with the data address compare (DAC) hit and the programmed DVC mode, and registers a DVC event into the WB stage. It maintains sticky DBSR DVC status bits and an overrun flag, and drives a registered request/acknowledge handshake to the debug exception logic. Sits between the load/store EXE data path and the debug/exception control unit.

## Interface
Parameters: none (byte-lane count fixed at 4, matching the 32-bit data path).
- CB  in  1  core clock; all state updates on rising edge
- coreReset_N  in  1  synchronous, active-low reset
- EXE_dvc1ByteCmp  in  [0:3]  DVC1 per-byte equal flags, already masked by byte enables
- EXE_dvc2ByteCmp  in  [0:3]  DVC2 per-byte equal flags, already masked by byte enables
- PCL_dvcByteEnL2  in  [0:3]  byte lanes accessed by the current load/store
- EXE_dac1Hit  in  1  DAC1 address match for the EXE load/store
- EXE_dac2Hit  in  1  DAC2 address match for the EXE load/store
- EXE_ldStValid  in  1  valid load/store in EXE this cycle
- EXE_flush  in  1  kill the EXE instruction; no event captured
- DBCR_dvc1Mode  in  [0:1]  00 off, 01 all-enabled-bytes, 10 any-byte, 11 halfword
- DBCR_dvc2Mode  in  [0:1]  same encoding for DVC2
- DBCR_idm  in  1  internal debug mode enable; gates the exception request
- DBSR_clrDvc  in  [0:1]  per-bit clear pulse for status (bit0 DVC1, bit1 DVC2), from mtspr DBSR
- DBSR_clrOvr  in  1  clear pulse for overrun flag
- DBG_excAck  in  1  debug exception accepted
- WB_dvc1Event  out  1  single-cycle DVC1 event pulse in WB
- WB_dvc2Event  out  1  single-cycle DVC2 event pulse in WB
- DBSR_dvc1  out  1  sticky DVC1 status
- DBSR_dvc2  out  1  sticky DVC2 status
- DBG_dvcOvr  out  1  sticky overrun: event arrived while a request was unacknowledged
- DBG_excReq  out  1  debug exception request, level, registered

## Operation
- Mode combine for DVCn, with b = EXE_dvcnByteCmp and e = PCL_dvcByteEnL2:
  - 01: match = (e != 0) & ((b & e) == e)
  - 10: match = |(b & e)
  - 11: match = (e[0]&e[1]&b[0]&b[1]) | (e[2]&e[3]&b[2]&b[3])
  - 00: match = 0
- Zero byte enables always give no match, in every mode.
- hitN = EXE_ldStValid & ~EXE_flush & EXE_dacNHit & matchN.
- Pipeline register: evN_q <= hitN, driving WB_dvcNEvent. Only one cycle is ever held; there is no buffering.
- Status: DBSR_dvcN <= (DBSR_dvcN & ~DBSR_clrDvc[N]) | hitN. Set wins over a simultaneous clear.
- Request FSM, two states:
  - IDLE (DBG_excReq=0): if newReq = DBCR_idm & (hit1|hit2), go to PEND.
  - PEND (DBG_excReq=1): on DBG_excAck with no newReq, go to IDLE. Ack with newReq stays in PEND, re-armed. No ack stays in PEND.
- Overrun: DBG_dvcOvr <= (DBG_dvcOvr & ~DBSR_clrOvr) | (newReq & DBG_excReq & ~DBG_excAck). Set wins over clear.
- DBCR_idm deasserting in PEND does not withdraw the request. The request is retired only by ack or reset.
- With DBCR_idm=0, status bits still set, but no request and no overrun.

## Timing
- Reset (coreReset_N=0 at an edge): all outputs 0, FSM in IDLE. Reset overrides all other inputs, including mid-PEND; the request drops the cycle after the reset edge.
- Latency: an EXE hit in cycle N produces WB_dvcNEvent, DBSR_dvcN and DBG_excReq all high in cycle N+1.
- WB_dvcNEvent is high for exactly one cycle per hit. Back-to-back hits give back-to-back pulses.
- Ack in cycle M drops DBG_excReq in M+1, unless a hit also occurs in M.
- Ack while in IDLE is ignored.
- A status clear in cycle M takes effect in M+1.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Mode 01, e=1111, b1=1111, dac1Hit=1, valid=1 → in N+1: WB_dvc1Event=1, DBSR_dvc1=1, DBG_excReq=1. Then b1=1110 → no event.
- Mode 10, e=0010, b2=0010 → DVC2 event. Mode 11, e=1100, b=1000 → no event. Same with b=1100 → event. e=0000 in all modes → no event.
- Hit with EXE_flush=1, or with dacHit=0 → all outputs remain 0.
- Hit; hold ack low; second hit two cycles later → DBG_dvcOvr=1, request stays high. Then ack → request 0 next cycle. DBSR_clrOvr → overrun 0.
- Ack coincident with a new hit → DBG_excReq stays 1 and overrun stays 0. Clear coincident with a hit → status stays 1.
- DBCR_idm=0 plus hit → status=1, request=0. Assert reset during PEND → all outputs 0 next cycle.

Source files
------------

// File: rtl/p405s_dvc_event_ctl.sv
// p405s_dvc_event_ctl
//
// Debug data-value-compare (DVC) event controller. It qualifies the per-byte
// DVC compare vectors from EXE with the DAC hit and the programmed DVC mode.
// The result is registered into WB as a one-cycle event pulse per comparator.
// The block also keeps the sticky DBSR DVC status bits and an overrun flag,
// and drives a registered request/acknowledge handshake to the debug
// exception logic.
//
// Ports
//   CB               core clock, rising edge
//   coreReset_N      synchronous active-low reset
//   EXE_dvc1ByteCmp  DVC1 per-byte equal flags [0:3]
//   EXE_dvc2ByteCmp  DVC2 per-byte equal flags [0:3]
//   PCL_dvcByteEnL2  byte lanes accessed by the load/store [0:3]
//   EXE_dac1Hit      DAC1 address match
//   EXE_dac2Hit      DAC2 address match
//   EXE_ldStValid    valid load/store in EXE
//   EXE_flush        kill the EXE instruction
//   DBCR_dvc1Mode    DVC1 mode: 00 off, 01 all bytes, 10 any byte, 11 halfword
//   DBCR_dvc2Mode    DVC2 mode, same encoding
//   DBCR_idm         internal debug mode; gates new exception requests
//   DBSR_clrDvc      status clear pulses, bit0 DVC1, bit1 DVC2
//   DBSR_clrOvr      overrun clear pulse
//   DBG_excAck       debug exception accepted
//   WB_dvc1Event     DVC1 event pulse in WB
//   WB_dvc2Event     DVC2 event pulse in WB
//   DBSR_dvc1        sticky DVC1 status
//   DBSR_dvc2        sticky DVC2 status
//   DBG_dvcOvr       sticky overrun flag
//   DBG_excReq       debug exception request (registered level)
//
// Handshake: DBG_excReq is a level that rises the cycle after a qualifying
// hit and holds until the cycle after DBG_excAck is seen high with it. An
// ack that coincides with a new hit keeps the request high, so the new
// event is re-armed. An ack seen while the request is low is ignored.
// DBG_excReq is the request FSM state bit itself (high exactly in PEND).
// This lets a checker read the FSM state from the port directly.

module p405s_dvc_event_ctl (
    input  logic       CB,
    input  logic       coreReset_N,
    input  logic [0:3] EXE_dvc1ByteCmp,
    input  logic [0:3] EXE_dvc2ByteCmp,
    input  logic [0:3] PCL_dvcByteEnL2,
    input  logic       EXE_dac1Hit,
    input  logic       EXE_dac2Hit,
    input  logic       EXE_ldStValid,
    input  logic       EXE_flush,
    input  logic [0:1] DBCR_dvc1Mode,
    input  logic [0:1] DBCR_dvc2Mode,
    input  logic       DBCR_idm,
    input  logic [0:1] DBSR_clrDvc,
    input  logic       DBSR_clrOvr,
    input  logic       DBG_excAck,
    output logic       WB_dvc1Event,
    output logic       WB_dvc2Event,
    output logic       DBSR_dvc1,
    output logic       DBSR_dvc2,
    output logic       DBG_dvcOvr,
    output logic       DBG_excReq
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } reqState_t;

    reqState_t reqState;

    // Mode combine. Zero byte enables never match: mode 01 tests e != 0
    // explicitly, and the other modes AND every term with e.
    function automatic logic dvcMatch(input logic [0:1] mode,
                                      input logic [0:3] b,
                                      input logic [0:3] e);
        logic m;
        case (mode)
            2'b01:   m = (e != 4'b0000) && ((b & e) == e);
            2'b10:   m = |(b & e);
            2'b11:   m = (e[0] & e[1] & b[0] & b[1]) | (e[2] & e[3] & b[2] & b[3]);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    logic qualify;
    logic hit1;
    logic hit2;
    logic newReq;

    always_comb begin
        qualify = EXE_ldStValid & ~EXE_flush;
        hit1    = qualify & EXE_dac1Hit
                  & dvcMatch(DBCR_dvc1Mode, EXE_dvc1ByteCmp, PCL_dvcByteEnL2);
        hit2    = qualify & EXE_dac2Hit
                  & dvcMatch(DBCR_dvc2Mode, EXE_dvc2ByteCmp, PCL_dvcByteEnL2);
        newReq  = DBCR_idm & (hit1 | hit2);
    end

    always_ff @(posedge CB) begin
        if (!coreReset_N) begin
            WB_dvc1Event <= 1'b0;
            WB_dvc2Event <= 1'b0;
            DBSR_dvc1    <= 1'b0;
            DBSR_dvc2    <= 1'b0;
            DBG_dvcOvr   <= 1'b0;
            DBG_excReq   <= 1'b0;
            reqState     <= IDLE;
        end else begin
            // Single-stage EXE->WB register; nothing is buffered.
            WB_dvc1Event <= hit1;
            WB_dvc2Event <= hit2;

            // Sticky status: a hit in the same cycle as a clear wins.
            DBSR_dvc1 <= (DBSR_dvc1 & ~DBSR_clrDvc[0]) | hit1;
            DBSR_dvc2 <= (DBSR_dvc2 & ~DBSR_clrDvc[1]) | hit2;

            // Overrun: a new request while the current one is still
            // outstanding and not being acknowledged this cycle.
            DBG_dvcOvr <= (DBG_dvcOvr & ~DBSR_clrOvr)
                          | (newReq & DBG_excReq & ~DBG_excAck);

            // Dropping DBCR_idm does not withdraw a pending request;
            // only ack or reset retires it.
            case (reqState)
                IDLE: begin
                    if (newReq) begin
                        reqState   <= PEND;
                        DBG_excReq <= 1'b1;
                    end
                end
                PEND: begin
                    if (DBG_excAck && !newReq) begin
                        reqState   <= IDLE;
                        DBG_excReq <= 1'b0;
                    end
                end
                default: begin
                    reqState   <= IDLE;
                    DBG_excReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_dvc_event_ctl.sv
// Testbench for p405s_dvc_event_ctl: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences. Each applied cycle pushes its
// expected output word to a queue, and the word is popped and compared one
// cycle later, after the clock edge.
// Output word layout: {WB_dvc1Event, WB_dvc2Event, DBSR_dvc1, DBSR_dvc2,
//                      DBG_dvcOvr, DBG_excReq}

module tb_p405s_dvc_event_ctl;

    localparam int W = 6;

    // ---------------- clock / reset ----------------
    logic CB = 1'b0;
    always #5 CB = ~CB;

    logic       coreReset_N;
    logic [0:3] EXE_dvc1ByteCmp;
    logic [0:3] EXE_dvc2ByteCmp;
    logic [0:3] PCL_dvcByteEnL2;
    logic       EXE_dac1Hit;
    logic       EXE_dac2Hit;
    logic       EXE_ldStValid;
    logic       EXE_flush;
    logic [0:1] DBCR_dvc1Mode;
    logic [0:1] DBCR_dvc2Mode;
    logic       DBCR_idm;
    logic [0:1] DBSR_clrDvc;
    logic       DBSR_clrOvr;
    logic       DBG_excAck;
    logic       WB_dvc1Event;
    logic       WB_dvc2Event;
    logic       DBSR_dvc1;
    logic       DBSR_dvc2;
    logic       DBG_dvcOvr;
    logic       DBG_excReq;

    p405s_dvc_event_ctl dut (
        .CB              (CB),
        .coreReset_N     (coreReset_N),
        .EXE_dvc1ByteCmp (EXE_dvc1ByteCmp),
        .EXE_dvc2ByteCmp (EXE_dvc2ByteCmp),
        .PCL_dvcByteEnL2 (PCL_dvcByteEnL2),
        .EXE_dac1Hit     (EXE_dac1Hit),
        .EXE_dac2Hit     (EXE_dac2Hit),
        .EXE_ldStValid   (EXE_ldStValid),
        .EXE_flush       (EXE_flush),
        .DBCR_dvc1Mode   (DBCR_dvc1Mode),
        .DBCR_dvc2Mode   (DBCR_dvc2Mode),
        .DBCR_idm        (DBCR_idm),
        .DBSR_clrDvc     (DBSR_clrDvc),
        .DBSR_clrOvr     (DBSR_clrOvr),
        .DBG_excAck      (DBG_excAck),
        .WB_dvc1Event    (WB_dvc1Event),
        .WB_dvc2Event    (WB_dvc2Event),
        .DBSR_dvc1       (DBSR_dvc1),
        .DBSR_dvc2       (DBSR_dvc2),
        .DBG_dvcOvr      (DBG_dvcOvr),
        .DBG_excReq      (DBG_excReq)
    );

    // ---------------- vector record ----------------
    typedef struct {
        logic         rstN;
        logic [0:1]   m1;
        logic [0:1]   m2;
        logic [0:3]   e;
        logic [0:3]   b1;
        logic [0:3]   b2;
        logic         dac1;
        logic         dac2;
        logic         valid;
        logic         flush;
        logic         idm;
        logic         ack;
        logic [0:1]   clr;
        logic         clrOvr;
        logic [W-1:0] exp;
    } vec_t;

    // ---------------- scoreboard ----------------
    logic [W-1:0] expQ[$];
    int checks = 0;
    int errors = 0;

    // Quiet cycle: out of reset, no load/store, modes 01, idm on.
    function automatic vec_t idleV(input logic [W-1:0] exp);
        vec_t v;
        v.rstN = 1'b1; v.m1 = 2'b01; v.m2 = 2'b01; v.e = 4'b1111;
        v.b1 = 4'b0000; v.b2 = 4'b0000; v.dac1 = 1'b0; v.dac2 = 1'b0;
        v.valid = 1'b0; v.flush = 1'b0; v.idm = 1'b1; v.ack = 1'b0;
        v.clr = 2'b00; v.clrOvr = 1'b0; v.exp = exp;
        return v;
    endfunction

    // Full-word DVC1 hit in mode 01.
    function automatic vec_t hit1V(input logic [W-1:0] exp);
        vec_t v;
        v = idleV(exp);
        v.valid = 1'b1; v.dac1 = 1'b1; v.b1 = 4'b1111;
        return v;
    endfunction

    function automatic vec_t mk(input logic [0:1] m1, input logic [0:1] m2,
                                input logic [0:3] e, input logic [0:3] b1,
                                input logic [0:3] b2, input logic dac1,
                                input logic dac2, input logic valid,
                                input logic flush, input logic idm,
                                input logic [W-1:0] exp);
        vec_t v;
        v = idleV(exp);
        v.m1 = m1; v.m2 = m2; v.e = e; v.b1 = b1; v.b2 = b2;
        v.dac1 = dac1; v.dac2 = dac2; v.valid = valid; v.flush = flush;
        v.idm = idm;
        return v;
    endfunction

    // ---------------- driver task ----------------
    task automatic runVec(input vec_t v, input string tag);
        logic [W-1:0] got;
        logic [W-1:0] want;
        @(negedge CB);
        coreReset_N     = v.rstN;
        DBCR_dvc1Mode   = v.m1;
        DBCR_dvc2Mode   = v.m2;
        PCL_dvcByteEnL2 = v.e;
        EXE_dvc1ByteCmp = v.b1;
        EXE_dvc2ByteCmp = v.b2;
        EXE_dac1Hit     = v.dac1;
        EXE_dac2Hit     = v.dac2;
        EXE_ldStValid   = v.valid;
        EXE_flush       = v.flush;
        DBCR_idm        = v.idm;
        DBG_excAck      = v.ack;
        DBSR_clrDvc     = v.clr;
        DBSR_clrOvr     = v.clrOvr;
        expQ.push_back(v.exp);
        @(posedge CB);
        #1;
        got  = {WB_dvc1Event, WB_dvc2Event, DBSR_dvc1, DBSR_dvc2,
                DBG_dvcOvr, DBG_excReq};
        want = expQ.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b (ev1 ev2 dvc1 dvc2 ovr req)",
                     tag, got, want);
        end
    endtask

    task automatic doReset(input string tag);
        vec_t v;
        v = idleV(6'b000000);
        v.rstN = 1'b0;
        runVec(v, tag);
    endtask

    // ---------------- table ----------------
    localparam int NT = 17;
    vec_t tbl[NT];

    initial begin
        vec_t v;

        //         m1     m2     e        b1       b2       d1 d2 vl fl idm  exp
        tbl[0]  = mk(2'b01, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 6'b101001);
        tbl[1]  = mk(2'b01, 2'b00, 4'b1111, 4'b1110, 4'b0000, 1, 0, 1, 0, 1, 6'b000000);
        tbl[2]  = mk(2'b00, 2'b10, 4'b0010, 4'b0000, 4'b0010, 0, 1, 1, 0, 1, 6'b010101);
        tbl[3]  = mk(2'b11, 2'b00, 4'b1100, 4'b1000, 4'b0000, 1, 0, 1, 0, 1, 6'b000000);
        tbl[4]  = mk(2'b11, 2'b00, 4'b1100, 4'b1100, 4'b0000, 1, 0, 1, 0, 1, 6'b101001);
        tbl[5]  = mk(2'b01, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 1, 1, 0, 1, 6'b000000);
        tbl[6]  = mk(2'b10, 2'b10, 4'b0000, 4'b1111, 4'b1111, 1, 1, 1, 0, 1, 6'b000000);
        tbl[7]  = mk(2'b11, 2'b11, 4'b0000, 4'b1111, 4'b1111, 1, 1, 1, 0, 1, 6'b000000);
        tbl[8]  = mk(2'b01, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1, 0, 1, 1, 1, 6'b000000);
        tbl[9]  = mk(2'b01, 2'b00, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 6'b000000);
        tbl[10] = mk(2'b01, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1, 0, 1, 0, 0, 6'b101000);
        tbl[11] = mk(2'b10, 2'b00, 4'b0101, 4'b0100, 4'b0000, 1, 0, 1, 0, 1, 6'b101001);
        tbl[12] = mk(2'b00, 2'b00, 4'b1111, 4'b1111, 4'b1111, 1, 1, 1, 0, 1, 6'b000000);
        tbl[13] = mk(2'b00, 2'b11, 4'b0011, 4'b0000, 4'b0011, 0, 1, 1, 0, 1, 6'b010101);
        tbl[14] = mk(2'b01, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 0, 1, 6'b000000);
        tbl[15] = mk(2'b01, 2'b10, 4'b1111, 4'b1111, 4'b0001, 1, 1, 1, 0, 1, 6'b111101);
        tbl[16] = mk(2'b01, 2'b00, 4'b0110, 4'b0111, 4'b0000, 1, 0, 1, 0, 1, 6'b101001);

        // Reset state.
        doReset("reset_state");

        // Each table row runs from a clean reset.
        for (int i = 0; i < NT; i++) begin
            doReset($sformatf("row%0d_reset", i));
            runVec(tbl[i], $sformatf("row%0d", i));
        end

        // Overrun: two hits without ack, then ack, then clears.
        doReset("ovr_reset");
        runVec(hit1V(6'b101001), "ovr_first_hit");
        runVec(idleV(6'b001001), "ovr_pulse_ends");
        runVec(hit1V(6'b101011), "ovr_second_hit");
        runVec(idleV(6'b001011), "ovr_held");
        v = idleV(6'b001010); v.ack = 1'b1;
        runVec(v, "ovr_ack_drops_req");
        v = idleV(6'b001000); v.clrOvr = 1'b1;
        runVec(v, "ovr_clear");
        v = idleV(6'b001000); v.clr[1] = 1'b1;
        runVec(v, "clr_dvc2_keeps_dvc1");
        v = idleV(6'b000000); v.clr[0] = 1'b1;
        runVec(v, "clr_dvc1");

        // Ack coincident with a hit keeps the request, no overrun.
        doReset("ackhit_reset");
        runVec(hit1V(6'b101001), "ackhit_first");
        v = hit1V(6'b101001); v.ack = 1'b1;
        runVec(v, "ackhit_rearm");
        v = idleV(6'b001000); v.ack = 1'b1;
        runVec(v, "ackhit_ack");
        v = idleV(6'b001000); v.ack = 1'b1;
        runVec(v, "ack_in_idle");

        // Clear coincident with a hit: set wins.
        v = hit1V(6'b101000); v.idm = 1'b0; v.clr[0] = 1'b1;
        runVec(v, "clr_with_hit");
        v = idleV(6'b000000); v.clr[0] = 1'b1;
        runVec(v, "clr_after_hit");

        // idm dropping in PEND does not withdraw the request.
        runVec(hit1V(6'b101001), "idm_hit");
        v = idleV(6'b001001); v.idm = 1'b0;
        runVec(v, "idm_drop_holds_req");
        v = hit1V(6'b101001); v.idm = 1'b0;
        runVec(v, "idm_off_hit_no_ovr");

        // Reset during PEND with an overrun pending.
        runVec(hit1V(6'b101011), "pre_reset_ovr");
        v = hit1V(6'b000000); v.rstN = 1'b0;
        runVec(v, "reset_in_pend");
        runVec(idleV(6'b000000), "after_reset");

        // Randomized mode-10 DVC2 sweep against a simple any-byte model.
        for (int i = 0; i < 16; i++) begin
            logic [0:3] e;
            logic [0:3] b;
            logic       m;
            doReset($sformatf("rnd%0d_reset", i));
            e = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            m = 1'b0;
            for (int k = 0; k < 4; k++) m = m | (e[k] & b[k]);
            runVec(mk(2'b00, 2'b10, e, 4'b0000, b, 0, 1, 1, 0, 1,
                      {1'b0, m, 1'b0, m, 1'b0, m}),
                   $sformatf("rnd%0d_e%b_b%b", i, e, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
